// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (hsync/vsync/de/frame_start) that starts and stops only on frame boundaries.
// Optional colour-bar test pattern on out_data when VTGEN_TEST_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int       WIDTH     = 24,
    parameter int       H_ACTIVE  = 640,
    parameter int       H_FP      = 16,
    parameter int       H_SYNC    = 96,
    parameter int       H_BP      = 48,
    parameter int       V_ACTIVE  = 480,
    parameter int       V_FP      = 10,
    parameter int       V_SYNC    = 2,
    parameter int       V_BP      = 33,
    parameter bit       HSYNC_POL = 1'b0,
    parameter bit       VSYNC_POL = 1'b0,
    parameter int       CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 busy,
    output logic                 frame_start,
    output logic                 out_vsync,
    output logic                 out_hsync,
    output logic                 out_de,
    output logic [WIDTH-1:0]     out_data,
    output logic [3:0]           out_ctl,
    output logic [CNT_WIDTH-1:0] out_h_count,
    output logic [CNT_WIDTH-1:0] out_v_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_ACT_C  = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_ACT_C  = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] HS_START = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] VS_START = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   h_q, h_d, v_q, v_d;
    logic [CNT_WIDTH-1:0]   h_adv, v_adv;
    logic                   line_end, frame_end, active;

    logic                   busy_q, fs_q, vsync_q, hsync_q, de_q;
    logic                   fs_d, vsync_d, hsync_d, de_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, vcnt_q;

    always_comb begin
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        h_adv     = line_end ? '0 : h_q + 1'b1;
        v_adv     = line_end ? (frame_end ? '0 : v_q + 1'b1) : v_q;
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                h_d = h_adv;
                v_d = v_adv;
                if (!enable) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                // Counting never pauses; only the frame wrap may return to idle.
                h_d = h_adv;
                v_d = v_adv;
                if (enable)         state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    assign active = (state_q == ST_RUN) || (state_q == ST_STOPPING);

    always_comb begin
        de_d    = active && (h_q < H_ACT_C) && (v_q < V_ACT_C);
        hsync_d = (active && (h_q >= HS_START) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (active && (v_q >= VS_START) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        fs_d    = active && (h_q == '0) && (v_q == '0);
    end

`ifdef VTGEN_TEST_PATTERN_EN
    localparam int CW = WIDTH / 3;

    logic [6:0]             bar_ge;
    logic [CNT_WIDTH+2:0]   h_x8;
    logic [2:0]             bar_idx;
    logic [3*CW-1:0]        rgb;

    // Bar index = h*8/H_ACTIVE as a thermometer of constant thresholds.
    assign h_x8 = {h_q, 3'b000};
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi-1] = (h_x8 >= (CNT_WIDTH+3)'(gi * H_ACTIVE));
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    // White, yellow, cyan, green, magenta, red, blue, black.
    assign rgb    = {{CW{~bar_idx[1]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[0]}}};
    assign data_d = de_d ? WIDTH'(rgb) : '0;
`else
    assign data_d = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            vsync_q <= ~VSYNC_POL;
            hsync_q <= ~HSYNC_POL;
            de_q    <= 1'b0;
            data_q  <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            busy_q  <= (state_d != ST_IDLE);
            fs_q    <= fs_d;
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            de_q    <= de_d;
            data_q  <= data_d;
            hcnt_q  <= h_q;
            vcnt_q  <= v_q;
        end
    end

    assign busy        = busy_q;
    assign frame_start = fs_q;
    assign out_vsync   = vsync_q;
    assign out_hsync   = hsync_q;
    assign out_de      = de_q;
    assign out_data    = data_q;
    assign out_ctl     = 4'd0;
    assign out_h_count = hcnt_q;
    assign out_v_count = vcnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 24x13 raster (16x8 active) so whole frames fit in a short run.
module tb_video_timing_gen;

    localparam int WIDTH = 24;
    localparam int CNTW  = 12;
    localparam int HT    = 24;   // 16 + 2 + 3 + 3
    localparam int VT    = 13;   // 8 + 1 + 2 + 2
    localparam int FRAME = HT * VT;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             busy, frame_start, out_vsync, out_hsync, out_de;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ctl;
    logic [CNTW-1:0]  out_h_count, out_v_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int k        = 0;
    int cyc      = 0;
    int last_fs  = -1;
    int fs_count = 0;
    int de_count = 0;

    video_timing_gen #(
        .WIDTH(WIDTH), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .busy(busy),
        .frame_start(frame_start), .out_vsync(out_vsync), .out_hsync(out_hsync),
        .out_de(out_de), .out_data(out_data), .out_ctl(out_ctl),
        .out_h_count(out_h_count), .out_v_count(out_v_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string ctx);
        chk({ctx, ":vsync"}, 32'(out_vsync), 32'd1);
        chk({ctx, ":hsync"}, 32'(out_hsync), 32'd1);
        chk({ctx, ":de"}, 32'(out_de), 32'd0);
        chk({ctx, ":data"}, 32'(out_data), 32'd0);
        chk({ctx, ":ctl"}, 32'(out_ctl), 32'd0);
        chk({ctx, ":h_count"}, 32'(out_h_count), 32'd0);
        chk({ctx, ":v_count"}, 32'(out_v_count), 32'd0);
        chk({ctx, ":frame_start"}, 32'(frame_start), 32'd0);
        chk({ctx, ":busy"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [23:0] exp_px(input int h);
        case (h / 2)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Advance n cycles; each observed output must match raster position k.
    task automatic track(input int n);
        for (int i = 0; i < n; i++) begin
            int h;
            int v;
            logic de_e;
            logic [23:0] data_e;
            h    = k % HT;
            v    = k / HT;
            de_e = (h < 16) && (v < 8);
`ifdef VTGEN_TEST_PATTERN_EN
            data_e = de_e ? exp_px(h) : 24'h0;
`else
            data_e = 24'h0;
`endif
            @(negedge clk);
            cyc++;
            chk("h_count", 32'(out_h_count), 32'(h));
            chk("v_count", 32'(out_v_count), 32'(v));
            chk("de", 32'(out_de), 32'(de_e));
            chk("hsync", 32'(out_hsync), (h >= 18 && h <= 20) ? 32'd0 : 32'd1);
            chk("vsync", 32'(out_vsync), (v >= 9 && v <= 10) ? 32'd0 : 32'd1);
            chk("frame_start", 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
            chk("data", 32'(out_data), 32'(data_e));
            chk("ctl", 32'(out_ctl), 32'd0);
            if (frame_start === 1'b1) begin
                fs_count++;
                if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
                last_fs = cyc;
            end
            if (out_de === 1'b1) de_count++;
            k = (k + 1) % FRAME;
        end
    endtask

    initial begin
        // Reset state, then idle with enable low after release.
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle("idle_no_enable");

        // Start: first frame_start two cycles after enable rises.
        enable = 1'b1;
        @(negedge clk);
        chk("start:frame_start", 32'(frame_start), 32'd0);
        chk("start:busy", 32'(busy), 32'd1);
        k = 0; last_fs = -1; fs_count = 0; de_count = 0;
        track(2 * FRAME);
        chk("two_frames:de_cycles", 32'(de_count), 32'd256);
        chk("two_frames:fs_count", 32'(fs_count), 32'd2);
        track(1);
        chk("third_frame:fs_count", 32'(fs_count), 32'd3);

        // Drop enable at v=3: the frame must finish, then go idle for good.
        track(3 * HT - 1);
        enable = 1'b0;
        fs_count = 0;
        track(FRAME - 3 * HT);
        @(negedge clk);
        chk_idle("stopped");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("stopped:frame_start", 32'(frame_start), 32'd0);
            chk("stopped:de", 32'(out_de), 32'd0);
            chk("stopped:busy", 32'(busy), 32'd0);
        end

        // Restart, drop at v=3, reassert at v=8: timing must stay continuous.
        enable = 1'b1;
        @(negedge clk);
        chk("restart:frame_start", 32'(frame_start), 32'd0);
        chk("restart:busy", 32'(busy), 32'd1);
        k = 0; last_fs = -1; fs_count = 0;
        track(3 * HT);
        enable = 1'b0;
        track(5 * HT);
        chk("stopping:busy", 32'(busy), 32'd1);
        enable = 1'b1;
        track(FRAME - 8 * HT);
        track(1);
        chk("reassert:fs_count", 32'(fs_count), 32'd2);
        chk("reassert:busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-frame at h=10, v=5.
        track(5 * HT + 10);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("async_reset");
        repeat (2) @(negedge clk);
        chk_idle("held_reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset:frame_start", 32'(frame_start), 32'd0);
        chk("post_reset:busy", 32'(busy), 32'd1);
        k = 0; last_fs = -1; fs_count = 0;
        track(30);
        chk("post_reset:fs_count", 32'(fs_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
